i2so_serializer: RTL and testbench
==================================

# i2so_serializer

I2S output serializer for the audio transmit path: the transmit-side counterpart of the i2si receive chain. Accepts 32-bit PCM words (left then right, alternating) over a data/xfc handshake, buffers one word per channel, and drives an I2S master bus (sck, ws, sd) from the system clock. Sits between the playback sample source and the chip's I2S output pads.

## Interface

**Parameters**
- DATA_W, 32: bits per channel slot; frame is 2*DATA_W sck periods.
- SCK_HALF, 4: clk cycles per sck half-period (≥1); sck period = 2*SCK_HALF clk.

**Ports**
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  serializer enable; 0 holds bus idle (reset state) but keeps the buffers.
- in_data  in  DATA_W  sample word.
- in_xfc  in  1  one-cycle transfer strobe; in_data valid this cycle.
- in_rdy  out  1  combinational: buffer for the next expected channel is empty.
- sck  out  1  I2S bit clock (registered).
- ws  out  1  word select; 0 = left, 1 = right (registered).
- sd  out  1  serial data, MSB first (registered).
- underrun  out  1  one-cycle pulse: slot load found its buffer empty.
- overflow  out  1  one-cycle pulse: in_xfc while in_rdy = 0.

## Operation

- Reset (rst = 1, or en = 0): sck = 0, ws = 0, sd = 0, underrun = 0, overflow = 0, div_cnt = 0, bit_cnt = 2*DATA_W-1, shift register = 0. rst also clears both buffer valid flags and sets wr_sel = left. en = 0 does not clear buffers or wr_sel.
- Input side: wr_sel selects the buffer (L/R). in_rdy = ~valid[wr_sel]. On in_xfc with in_rdy = 1: store in_data in buf[wr_sel], set valid, toggle wr_sel. On in_xfc with in_rdy = 0: drop word, pulse overflow, wr_sel unchanged.
- Divider: div_cnt counts 0..SCK_HALF-1; at terminal count it wraps and sck toggles. 1→0 toggle = falling event; 0→1 = rising event (no other action).
- On each falling event: bit_cnt ← (bit_cnt+1) mod 2*DATA_W.
  - New bit_cnt = 0: load shift register from left buffer. New bit_cnt = DATA_W: load from right buffer.
  - Load with valid = 1: sd ← MSB, clear valid. Load with valid = 0: shift register = 0, sd ← 0, pulse underrun.
  - Other bit_cnt values: shift left; sd ← next bit.
  - ws ← channel of bit index (new bit_cnt+1) mod 2*DATA_W: ws leads data by one sck period (standard I2S), so ws falls at right-LSB and rises at left-LSB.
- Same-cycle load and in_xfc on the same buffer: load consumes the old content (or flags underrun if empty); the written word is stored after the load and held for the next frame. in_rdy uses pre-load valid.
- Sample accounting: one left and one right word consumed per 2*DATA_W*2*SCK_HALF clk cycles.

## Timing

- sck, ws, sd change only on the clk edge that follows a divider terminal count. sd and ws change coincident with sck falling; receiver samples on sck rising.
- From reset release with en = 1: first sck rise after SCK_HALF clk cycles. First falling event (left MSB on sd) after 2*SCK_HALF clk cycles.
- ws = 0 from reset through the first left slot. ws goes to 1 at the falling event where bit_cnt becomes DATA_W-1 (left LSB). ws goes to 0 where bit_cnt becomes 2*DATA_W-1.
- underrun asserts the clk cycle after the load falling event, aligned with the sd update; it is high for exactly 1 clk.
- overflow asserts 1 clk after the offending in_xfc.
- rst mid-frame: all bus outputs return to reset values on the next clk. The partial frame is abandoned; buffers are cleared.
- en dropped mid-frame: bus returns to idle; the buffers keep their data. The next enable restarts at the left slot, using the buffered words.

## Test plan

- Basic frame: DATA_W = 32, SCK_HALF = 2. Write 32'd25 (L), then 32'd50 (R) before enable; en = 1 → left slot shifts 25 MSB-first and right slot shifts 50. ws = 0 for sck bits 0..30 and 63, ws = 1 for bits 31..62. No underrun.
- Underrun: enable with empty buffers → sd = 0 for the whole frame. underrun pulses twice (left load, right load), each for 1 clk.
- Overflow: write 32'd100 (L) and 32'd1000 (R), then write 32'd2048 before any load → overflow pulse. The 2048 word is dropped; the frame carries 100/1000.
- Same-cycle load/write: right buffer empty at the right-slot load, with in_xfc of 32'd4096 (R) on that cycle → underrun pulse and right slot = 0. The next frame's right slot carries 4096.
- Reset mid-frame: assert rst at bit_cnt = 40 → next clk: sck = ws = sd = 0, in_rdy = 1, wr_sel = left. A restart produces a clean left MSB after 2*SCK_HALF cycles.
- Continuous stream: feed 8 alternating words whenever in_rdy = 1, with SCK_HALF = 1 → all words appear in order with correct ws alignment. No underrun or overflow.

Source files
------------

// File: rtl/i2so_serializer_if.sv
// I2S serializer bus bundle: sample-word handshake, enable and the I2S pins.
//   en        : serializer enable (source -> serializer)
//   in_data   : sample word, in_xfc qualifies it for one cycle
//   in_rdy    : buffer for the next expected channel is empty (combinational)
//   sck/ws/sd : I2S master bit clock, word select, serial data
//   underrun  : slot load found its buffer empty (1-clk pulse)
//   overflow  : in_xfc arrived while in_rdy was low (1-clk pulse)
interface i2so_serializer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              en;
    logic [DATA_W-1:0] in_data;
    logic              in_xfc;
    logic              in_rdy;
    logic              sck;
    logic              ws;
    logic              sd;
    logic              underrun;
    logic              overflow;

    // Sample source side
    modport master (
        output en, in_data, in_xfc,
        input  in_rdy, sck, ws, sd, underrun, overflow
    );

    // Serializer side
    modport slave (
        input  en, in_data, in_xfc,
        output in_rdy, sck, ws, sd, underrun, overflow
    );
endinterface

// File: rtl/i2so_serializer.sv
// I2S output serializer: buffers one PCM word per channel (left, then right)
// and shifts them MSB first onto an I2S master bus clocked from clk.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : i2so_serializer_if.slave (en, in_data/in_xfc/in_rdy, sck/ws/sd,
//         underrun, overflow)
module i2so_serializer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SCK_HALF = 4
) (
    input  logic             clk,
    input  logic             rst,
    i2so_serializer_if.slave bus
);
    localparam int unsigned FRAME_W = 2 * DATA_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned DIV_W   = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_HALF - 1);

    // Bus-side state
    logic [DIV_W-1:0]  r_div_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_sck;
    logic              r_ws;
    logic              r_underrun;

    // Input-side state
    logic [DATA_W-1:0] r_buf [2];
    logic [1:0]        r_valid;
    logic              r_wr_sel;
    logic              r_overflow;

    logic              w_tc;
    logic              w_fall;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [BIT_W-1:0]  w_ws_idx;
    logic              w_load;
    logic              w_ld_sel;
    logic              w_ld_valid;
    logic [DATA_W-1:0] w_ld_word;
    logic              w_in_rdy;
    logic              w_wr;

    // Divider terminal count and bit/slot bookkeeping for the falling event
    always_comb begin
        w_tc       = (r_div_cnt == DIV_LAST);
        // en gating matters: on the cycle en drops, a stale terminal count
        // must not consume a buffer.
        w_fall     = w_tc & r_sck & bus.en;
        w_bit_nxt  = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
        // ws leads data by one bit period
        w_ws_idx   = (w_bit_nxt == BIT_LAST) ? '0 : w_bit_nxt + BIT_W'(1);
        w_ld_sel   = (w_bit_nxt == BIT_RIGHT);
        w_load     = w_fall & ((w_bit_nxt == '0) | w_ld_sel);
        w_ld_valid = r_valid[w_ld_sel];
        w_ld_word  = r_buf[w_ld_sel];
        w_in_rdy   = ~r_valid[r_wr_sel];
        w_wr       = bus.in_xfc & w_in_rdy;
    end

    // I2S bus generation; en low holds the bus at its reset state
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= BIT_LAST;
            r_shift    <= '0;
            r_sck      <= 1'b0;
            r_ws       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_tc) begin
                r_div_cnt <= '0;
                r_sck     <= ~r_sck;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_ws      <= (w_ws_idx >= BIT_RIGHT);
                if (w_load) begin
                    if (w_ld_valid) begin
                        r_shift <= w_ld_word;
                    end else begin
                        r_shift    <= '0;
                        r_underrun <= 1'b1;
                    end
                end else begin
                    r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // Word buffers; a same-cycle load reads the old word, the write lands after
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_wr_sel   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= bus.en & bus.in_xfc & ~w_in_rdy;
            if (w_load && w_ld_valid) begin
                r_valid[w_ld_sel] <= 1'b0;
            end
            if (w_wr) begin
                r_buf[r_wr_sel]   <= bus.in_data;
                r_valid[r_wr_sel] <= 1'b1;
                r_wr_sel          <= ~r_wr_sel;
            end
        end
    end

    // sd is the shift register MSB, so it is a register output
    assign bus.in_rdy   = w_in_rdy;
    assign bus.sck      = r_sck;
    assign bus.ws       = r_ws;
    assign bus.sd       = r_shift[DATA_W-1];
    assign bus.underrun = r_underrun;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_i2so_serializer.sv
`timescale 1ns/1ps
module tb_i2so_serializer;
    localparam int DW   = 32;
    localparam int SH_A = 2;
    localparam int SH_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2so_serializer_if #(.DATA_W(DW)) ifa ();
    i2so_serializer_if #(.DATA_W(DW)) ifb ();

    i2so_serializer #(.DATA_W(DW), .SCK_HALF(SH_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    i2so_serializer #(.DATA_W(DW), .SCK_HALF(SH_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: buffers, sample-time arithmetic, per-instance
    logic [DW-1:0] m_buf   [2][2];
    bit   [1:0]    m_valid [2];
    bit            m_wr    [2];
    int            m_t     [2];
    logic [DW-1:0] m_word  [2];
    bit            m_under [2];
    bit            m_ovf   [2];

    task automatic model_step(input int i, input bit r, input bit en, input bit xfc,
                              input logic [DW-1:0] d);
        int sh;
        int f;
        bit rdy;
        bit c;
        sh = (i == 0) ? SH_A : SH_B;
        if (r) begin
            m_valid[i] = 2'b00;
            m_wr[i]    = 1'b0;
            m_t[i]     = 0;
            m_word[i]  = '0;
            m_under[i] = 1'b0;
            m_ovf[i]   = 1'b0;
        end else begin
            rdy        = !m_valid[i][m_wr[i]];
            m_ovf[i]   = en && xfc && !rdy;
            m_under[i] = 1'b0;
            if (!en) begin
                m_t[i]    = 0;
                m_word[i] = '0;
            end else begin
                m_t[i]++;
                if (m_t[i] % (2 * sh) == 0) begin
                    f = m_t[i] / (2 * sh);
                    if ((f - 1) % DW == 0) begin
                        c = (((f - 1) / DW) % 2) == 1;
                        if (m_valid[i][c]) begin
                            m_word[i]     = m_buf[i][c];
                            m_valid[i][c] = 1'b0;
                        end else begin
                            m_word[i]  = '0;
                            m_under[i] = 1'b1;
                        end
                    end
                end
            end
            if (xfc && rdy) begin
                m_buf[i][m_wr[i]]   = d;
                m_valid[i][m_wr[i]] = 1'b1;
                m_wr[i]             = !m_wr[i];
            end
        end
    endtask

    task automatic model_compare(input int i, input logic sck, input logic ws, input logic sd,
                                 input logic rdy, input logic und, input logic ovf);
        int sh;
        int f;
        int b;
        bit e_ws;
        bit e_sd;
        string p;
        sh = (i == 0) ? SH_A : SH_B;
        p  = (i == 0) ? "a" : "b";
        f  = m_t[i] / (2 * sh);
        e_ws = 1'b0;
        e_sd = 1'b0;
        if (f > 0) begin
            b    = (f - 1) % (2 * DW);
            e_ws = ((b + 1) % (2 * DW)) >= DW;
            e_sd = m_word[i][DW - 1 - (b % DW)];
        end
        check({p, ".sck"}, 32'(sck), 32'(((m_t[i] / sh) % 2) == 1));
        check({p, ".ws"}, 32'(ws), 32'(e_ws));
        check({p, ".sd"}, 32'(sd), 32'(e_sd));
        check({p, ".in_rdy"}, 32'(rdy), 32'(!m_valid[i][m_wr[i]]));
        check({p, ".underrun"}, 32'(und), 32'(m_under[i]));
        check({p, ".overflow"}, 32'(ovf), 32'(m_ovf[i]));
    endtask

    bit            chk_on = 1'b0;
    int            obs_under [2];
    int            obs_ovf   [2];
    int            rx_j = 0;
    logic [DW-1:0] rx_acc = '0;
    logic [DW-1:0] rx_q [$];
    logic          rx_prev_sck = 1'b0;

    // Model stepping, per-cycle comparison and an I2S receiver on instance b
    always @(posedge clk) begin
        bit rst_s;
        bit enb_s;
        rst_s = rst;
        enb_s = ifb.en;
        model_step(0, rst, ifa.en, ifa.in_xfc, ifa.in_data);
        model_step(1, rst, ifb.en, ifb.in_xfc, ifb.in_data);
        #1;
        if (chk_on) begin
            model_compare(0, ifa.sck, ifa.ws, ifa.sd, ifa.in_rdy, ifa.underrun, ifa.overflow);
            model_compare(1, ifb.sck, ifb.ws, ifb.sd, ifb.in_rdy, ifb.underrun, ifb.overflow);
            obs_under[0] += int'(ifa.underrun);
            obs_under[1] += int'(ifb.underrun);
            obs_ovf[0]   += int'(ifa.overflow);
            obs_ovf[1]   += int'(ifb.overflow);
        end
        if (rst_s || !enb_s) begin
            rx_j   = 0;
            rx_acc = '0;
        end else if (ifb.sck && !rx_prev_sck) begin
            if (rx_j >= 1) begin
                rx_acc = {rx_acc[DW-2:0], ifb.sd};
                if (((rx_j - 1) % DW) == DW - 1) rx_q.push_back(rx_acc);
            end
            rx_j++;
        end
        rx_prev_sck = ifb.sck;
    end

    typedef struct {
        bit            en;
        bit            xfc;
        logic [DW-1:0] d;
        bit            rdy;
        bit            ovf;
    } vec_t;

    vec_t          tbl [8];
    logic [DW-1:0] sent [$];
    int            base_u;
    int            base_o;
    int            rx_base;

    initial begin
        tbl[0] = '{en: 1'b0, xfc: 1'b1, d: 32'd25,   rdy: 1'b1, ovf: 1'b0};
        tbl[1] = '{en: 1'b0, xfc: 1'b1, d: 32'd50,   rdy: 1'b1, ovf: 1'b0};
        tbl[2] = '{en: 1'b0, xfc: 1'b0, d: 32'd0,    rdy: 1'b0, ovf: 1'b0};
        tbl[3] = '{en: 1'b1, xfc: 1'b1, d: 32'd2048, rdy: 1'b0, ovf: 1'b1};
        tbl[4] = '{en: 1'b1, xfc: 1'b0, d: 32'd0,    rdy: 1'b0, ovf: 1'b0};
        tbl[5] = '{en: 1'b1, xfc: 1'b0, d: 32'd0,    rdy: 1'b0, ovf: 1'b0};
        tbl[6] = '{en: 1'b1, xfc: 1'b0, d: 32'd0,    rdy: 1'b0, ovf: 1'b0};
        tbl[7] = '{en: 1'b1, xfc: 1'b0, d: 32'd0,    rdy: 1'b1, ovf: 1'b0};

        rst = 1'b1;
        ifa.en = 1'b0; ifa.in_xfc = 1'b0; ifa.in_data = '0;
        ifb.en = 1'b0; ifb.in_xfc = 1'b0; ifb.in_data = '0;
        tick();
        tick();
        chk_on = 1'b1;

        // Reset state
        check("rst.sck", 32'(ifa.sck), 32'd0);
        check("rst.ws", 32'(ifa.ws), 32'd0);
        check("rst.sd", 32'(ifa.sd), 32'd0);
        check("rst.in_rdy", 32'(ifa.in_rdy), 32'd1);
        rst = 1'b0;

        // Preload 25/50, overflow with 2048, then run the basic frame
        base_u = obs_under[0];
        for (int k = 0; k < 8; k++) begin
            ifa.en      = tbl[k].en;
            ifa.in_xfc  = tbl[k].xfc;
            ifa.in_data = tbl[k].d;
            check($sformatf("tbl%0d.in_rdy", k), 32'(ifa.in_rdy), 32'(tbl[k].rdy));
            tick();
            check($sformatf("tbl%0d.overflow", k), 32'(ifa.overflow), 32'(tbl[k].ovf));
        end
        ifa.in_xfc = 1'b0;
        repeat (119) tick();
        check("frame.b30.ws", 32'(ifa.ws), 32'd0);
        check("frame.b30.sd", 32'(ifa.sd), 32'd0);
        repeat (4) tick();
        check("frame.b31.ws", 32'(ifa.ws), 32'd1);
        check("frame.b31.sd", 32'(ifa.sd), 32'd1);
        repeat (124) tick();
        check("frame.b62.ws", 32'(ifa.ws), 32'd1);
        check("frame.b62.sd", 32'(ifa.sd), 32'd1);
        repeat (4) tick();
        check("frame.b63.ws", 32'(ifa.ws), 32'd0);
        check("frame.b63.sd", 32'(ifa.sd), 32'd0);
        repeat (2) tick();
        check("frame.no_underrun", 32'(obs_under[0] - base_u), 32'd0);
        ifa.en = 1'b0;
        tick();

        // Underrun: empty buffers for a whole frame
        rst = 1'b1; tick(); rst = 1'b0;
        base_u = obs_under[0];
        ifa.en = 1'b1;
        repeat (258) tick();
        check("underrun.count", 32'(obs_under[0] - base_u), 32'd2);
        ifa.en = 1'b0;
        tick();

        // Same-cycle right load and right write
        rst = 1'b1; tick(); rst = 1'b0;
        ifa.in_xfc = 1'b1; ifa.in_data = 32'd7;
        tick();
        ifa.in_xfc = 1'b0;
        ifa.en = 1'b1;
        repeat (131) tick();
        ifa.in_xfc = 1'b1; ifa.in_data = 32'd4096;
        check("same.in_rdy", 32'(ifa.in_rdy), 32'd1);
        tick();
        ifa.in_xfc = 1'b0;
        check("same.underrun", 32'(ifa.underrun), 32'd1);
        repeat (256) tick();
        check("same.next_right_load", 32'(ifa.underrun), 32'd0);
        repeat (72) tick();
        check("same.bit13", 32'(ifa.sd), 32'd0);
        repeat (4) tick();
        check("same.bit12", 32'(ifa.sd), 32'd1);
        ifa.en = 1'b0;
        tick();

        // Reset mid-frame at bit 40, then clean restart
        rst = 1'b1; tick(); rst = 1'b0;
        ifa.in_xfc = 1'b1; ifa.in_data = 32'hFFFF_FFFF;
        tick();
        ifa.in_data = 32'hFFFF_0000;
        tick();
        ifa.in_xfc = 1'b0;
        ifa.en = 1'b1;
        repeat (164) tick();
        rst = 1'b1;
        tick();
        check("midrst.sck", 32'(ifa.sck), 32'd0);
        check("midrst.ws", 32'(ifa.ws), 32'd0);
        check("midrst.sd", 32'(ifa.sd), 32'd0);
        check("midrst.in_rdy", 32'(ifa.in_rdy), 32'd1);
        rst = 1'b0;
        ifa.en = 1'b0;
        ifa.in_xfc = 1'b1; ifa.in_data = 32'h8000_0001;
        tick();
        ifa.in_xfc = 1'b0;
        check("midrst.wr_sel_right", 32'(ifa.in_rdy), 32'd1);
        ifa.en = 1'b1;
        repeat (3) tick();
        check("restart.pre_sd", 32'(ifa.sd), 32'd0);
        tick();
        check("restart.msb", 32'(ifa.sd), 32'd1);
        check("restart.ws", 32'(ifa.ws), 32'd0);
        ifa.en = 1'b0;
        tick();

        // Continuous stream on the SCK_HALF=1 instance
        rst = 1'b1; tick(); rst = 1'b0;
        base_u  = obs_under[1];
        base_o  = obs_ovf[1];
        rx_base = rx_q.size();
        ifb.en  = 1'b1;
        for (int cyc = 0; cyc < 513; cyc++) begin
            if (sent.size() < 8 && ifb.in_rdy) begin
                ifb.in_xfc  = 1'b1;
                ifb.in_data = $urandom;
                sent.push_back(ifb.in_data);
            end else begin
                ifb.in_xfc = 1'b0;
            end
            tick();
        end
        ifb.in_xfc = 1'b0;
        ifb.en     = 1'b0;
        tick();
        check("stream.sent", 32'(sent.size()), 32'd8);
        check("stream.underrun", 32'(obs_under[1] - base_u), 32'd0);
        check("stream.overflow", 32'(obs_ovf[1] - base_o), 32'd0);
        check("stream.rx_count", 32'(rx_q.size() - rx_base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (rx_base + k < rx_q.size() && k < sent.size()) begin
                check($sformatf("stream.word%0d", k), rx_q[rx_base + k], sent[k]);
            end
        end

        // Random traffic with occasional reset and enable toggles
        ifa.en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) ifa.en = ~ifa.en;
            ifa.in_xfc  = ($urandom_range(0, 2) == 0);
            ifa.in_data = $urandom;
            tick();
        end
        rst = 1'b0;
        ifa.in_xfc = 1'b0;
        ifa.en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
